// File: rtl/alu_4bit_if.sv
// alu_4bit_if - operand/result bundle for the registered 4-bit ALU.
//
// Signals:
//   a, b   operands (unsigned, WIDTH bits)
//   cin    carry-in, only meaningful for ADD/SUB
//   s_op   operation select (00 ADD, 01 SUB, 10 AND, 11 OR)
//   z      registered result
//   cout   registered carry-out
//   zero   registered flag, high when z is all zeros
//   ovf    registered two's-complement overflow flag
//
// The master side drives operands and reads results; the slave side is the ALU.
interface alu_4bit_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [1:0]       s_op;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             zero;
  logic             ovf;

  modport master (
    output a, b, cin, s_op,
    input  z, cout, zero, ovf
  );

  modport slave (
    input  a, b, cin, s_op,
    output z, cout, zero, ovf
  );
endinterface

// File: rtl/alu_4bit.sv
// alu_4bit - registered ALU with ripple-carry adder/subtractor and two logic ops.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (z=0, cout=0, zero=1, ovf=0)
//   bus    alu_4bit_if slave modport: a, b, cin, s_op in; z, cout, zero, ovf out
//
// Operands sampled at a rising edge produce results that are visible right after
// that edge and held until the next one: one-cycle latency, one operation per cycle.
module alu_4bit #(
  parameter int WIDTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_4bit_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } opSel_e;

  opSel_e           opSel;
  logic [WIDTH-1:0] bAdj;
  logic [WIDTH-1:0] propagate;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  logic [WIDTH-1:0] z_d, z_q;
  logic             cout_d, cout_q;
  logic             zero_d, zero_q;
  logic             ovf_d, ovf_q;

  assign opSel = opSel_e'(bus.s_op);

  // Subtraction reuses the adder: b is inverted going in and cin supplies the +1
  // (or not, giving a-b-1), so there is only one carry chain in the design.
  assign bAdj     = (opSel == OP_SUB) ? ~bus.b : bus.b;
  assign carry[0] = bus.cin;

  // One full-adder slice per bit; the carry ripples from bit 0 upward, with each
  // slice forming its own propagate/generate terms.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : gSlice
    assign propagate[gi] = bus.a[gi] ^ bAdj[gi];
    assign gen[gi]       = bus.a[gi] & bAdj[gi];
    assign sum[gi]       = propagate[gi] ^ carry[gi];
    assign carry[gi+1]   = gen[gi] | (propagate[gi] & carry[gi]);
  end

  // Next-state selection. Overflow is the disagreement between the carry into the
  // MSB and the carry out of it, which is exactly signed overflow for ADD/SUB.
  // Logic ops never report a carry or an overflow.
  always_comb begin
    z_d    = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    case (opSel)
      OP_ADD, OP_SUB: begin
        z_d    = sum;
        cout_d = carry[WIDTH];
        ovf_d  = carry[WIDTH] ^ carry[WIDTH-1];
      end
      OP_AND: z_d = bus.a & bus.b;
      OP_OR:  z_d = bus.a | bus.b;
      default: z_d = '0;
    endcase
    zero_d = (z_d == '0);
  end

  // Result registers. Reset wins over whatever operation is presented in the same
  // cycle, so an in-flight result is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      z_q    <= z_d;
      cout_q <= cout_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.z    = z_q;
  assign bus.cout = cout_q;
  assign bus.zero = zero_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit - self-checking bench for alu_4bit.
//
// A behavioural model computes the expected outputs from plain integer arithmetic
// at every rising edge; a compare process checks the DUT against it on every
// falling edge. Directed vectors additionally carry hand-computed expectations.
module tb_alu_4bit;

  localparam int W = 4;
  localparam int MOD = 2 ** W;

  logic clk;
  logic rst_n;

  alu_4bit_if #(.WIDTH(W)) bus ();

  alu_4bit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] expZ;
  logic         expCout;
  logic         expZero;
  logic         expOvf;
  logic         modelValid = 1'b0;

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: unsigned sum for z/cout, signed interpretation for ovf.
  always @(posedge clk) begin
    int ua, ub, sa, sb, u, s;
    ua = int'(bus.a);
    ub = int'(bus.b);
    sa = (ua >= MOD / 2) ? ua - MOD : ua;
    sb = (ub >= MOD / 2) ? ub - MOD : ub;
    if (!rst_n) begin
      expZ    = '0;
      expCout = 1'b0;
      expOvf  = 1'b0;
    end else begin
      case (bus.s_op)
        2'b00: begin
          u = ua + ub + int'(bus.cin);
          s = sa + sb + int'(bus.cin);
          expZ    = W'(u % MOD);
          expCout = (u >= MOD);
          expOvf  = (s > MOD / 2 - 1) || (s < -MOD / 2);
        end
        2'b01: begin
          u = ua + (MOD - 1 - ub) + int'(bus.cin);
          s = sa - sb - 1 + int'(bus.cin);
          expZ    = W'(u % MOD);
          expCout = (u >= MOD);
          expOvf  = (s > MOD / 2 - 1) || (s < -MOD / 2);
        end
        2'b10: begin
          expZ    = bus.a & bus.b;
          expCout = 1'b0;
          expOvf  = 1'b0;
        end
        default: begin
          expZ    = bus.a | bus.b;
          expCout = 1'b0;
          expOvf  = 1'b0;
        end
      endcase
    end
    expZero    = (expZ == '0);
    modelValid = 1'b1;
  end

  // Compare the DUT to the model on every falling edge once the model has data.
  always @(negedge clk) begin
    if (modelValid) begin
      checks += 4;
      if (bus.z !== expZ) begin
        failures++;
        $display("[TB] FAIL model_z t=%0t: got %h expected %h", $time, bus.z, expZ);
      end
      if (bus.cout !== expCout) begin
        failures++;
        $display("[TB] FAIL model_cout t=%0t: got %b expected %b", $time, bus.cout, expCout);
      end
      if (bus.zero !== expZero) begin
        failures++;
        $display("[TB] FAIL model_zero t=%0t: got %b expected %b", $time, bus.zero, expZero);
      end
      if (bus.ovf !== expOvf) begin
        failures++;
        $display("[TB] FAIL model_ovf t=%0t: got %b expected %b", $time, bus.ovf, expOvf);
      end
    end
  end

  // Drive one vector just after a falling edge, then wait until the falling edge
  // after the next rising edge so its result is settled.
  task automatic applyStimulus(input logic rstN, input logic [1:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin);
    rst_n    = rstN;
    bus.s_op = op;
    bus.a    = a;
    bus.b    = b;
    bus.cin  = cin;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hand-computed expectation check on the currently visible outputs.
  task automatic checkOutput(input string name, input logic [W-1:0] z,
                             input logic cout, input logic zero, input logic ovf);
    checks++;
    if (bus.z !== z || bus.cout !== cout || bus.zero !== zero || bus.ovf !== ovf) begin
      failures++;
      $display("[TB] FAIL %s: got z=%h cout=%b zero=%b ovf=%b expected z=%h cout=%b zero=%b ovf=%b",
               name, bus.z, bus.cout, bus.zero, bus.ovf, z, cout, zero, ovf);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.s_op = 2'b00;
    bus.a    = 4'hF;
    bus.b    = 4'hF;
    bus.cin  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", 4'h0, 1'b0, 1'b1, 1'b0);

    // Idle with all-zero logic op, held for two cycles.
    applyStimulus(1'b1, 2'b10, 4'h0, 4'h0, 1'b0);
    checkOutput("idle", 4'h0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_hold", 4'h0, 1'b0, 1'b1, 1'b0);

    applyStimulus(1'b1, 2'b00, 4'h7, 4'h1, 1'b0);
    checkOutput("add_7_1", 4'h8, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b00, 4'hF, 4'h1, 1'b0);
    checkOutput("add_F_1", 4'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b00, 4'h3, 4'h4, 1'b1);
    checkOutput("add_3_4_c", 4'h8, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 2'b01, 4'h5, 4'h3, 1'b1);
    checkOutput("sub_5_3", 4'h2, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 4'h3, 4'h5, 1'b1);
    checkOutput("sub_3_5", 4'hE, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 4'h8, 4'h1, 1'b1);
    checkOutput("sub_8_1", 4'h7, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b01, 4'h5, 4'h3, 1'b0);
    checkOutput("sub_5_3_nc", 4'h1, 1'b1, 1'b0, 1'b0);

    applyStimulus(1'b1, 2'b10, 4'hC, 4'hA, 1'b1);
    checkOutput("and_C_A", 4'h8, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 4'hC, 4'hA, 1'b1);
    checkOutput("or_C_A", 4'hE, 1'b0, 1'b0, 1'b0);

    // Back-to-back operations with a one-cycle reset in the middle.
    applyStimulus(1'b1, 2'b00, 4'h9, 4'h9, 1'b0);
    checkOutput("b2b_add", 4'h2, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 2'b11, 4'h0, 4'h0, 1'b1);
    checkOutput("b2b_or0", 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 4'hF, 4'hF, 1'b1);
    checkOutput("mid_reset", 4'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 2'b00, 4'h2, 4'h3, 1'b0);
    checkOutput("resume_add", 4'h5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 4'h0, 4'h0, 1'b0);
    checkOutput("sub_0_0_nc", 4'hF, 1'b0, 1'b0, 1'b0);

    // A short sweep of mixed operands, checked by the model only.
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 2'(i % 4), 4'((i * 7 + 3) % 16), 4'((i * 5 + 11) % 16), 1'(i / 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
